i2c_codec_config_sequencer: RTL and testbench

Parametrised successor to the fixed-table codec I2C loader. Walks an external register-write table of NUM_ENTRIES words and issues one complete I2C write transaction per entry: START, device address with W bit, NB data bytes, STOP. Generates SCL itself from a programmable divider, checks every ACK, and retries NACKed entries. Reports busy/done/error status to the audio top level. Sits between the codec config ROM and the open-drain I2C pads.

---
 rtl/i2c_codec_config_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_i2c_codec_config_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_config_sequencer.sv
// i2c_codec_config_sequencer
// Walks an external table of NUM_ENTRIES register words. For each word it
// issues one I2C write: START, {DEV_ADDR, W}, DATA_W/8 data bytes (MSB byte
// first), STOP, then a short bus-idle gap. SCL is generated locally. Every
// ACK is checked. A NACKed entry is aborted and retried up to MAX_RETRY times
// before the sequence stops with an error.
//
// Ports:
//   i_CLK        system clock
//   i_NRESET     synchronous active-low reset; also aborts a transfer
//   i_START      one-cycle pulse; starts a sequence when idle
//   o_TableAddr  table read address (registered)
//   i_TableData  table word; combinational or one cycle after o_TableAddr
//   o_SCL        SCL level, 1 = released
//   o_SDA_OE     1 = pull SDA low
//   i_SDA        SDA pad level, used for ACK sampling
//   o_BUSY       sequence in progress
//   o_DONE       sticky: sequence finished (success or error)
//   o_ERROR      sticky: an entry ran out of retries
//   o_FailIndex  index of the failing entry, valid with o_ERROR
module i2c_codec_config_sequencer #(
   parameter int         CLK_DIV     = 125,
   parameter logic [6:0] DEV_ADDR    = 7'b0011010,
   parameter int         NUM_ENTRIES = 10,
   parameter int         ADDR_W      = 5,
   parameter int         DATA_W      = 16,
   parameter int         MAX_RETRY   = 3
) (
   input  logic              i_CLK,
   input  logic              i_NRESET,
   input  logic              i_START,
   output logic [ADDR_W-1:0] o_TableAddr,
   input  logic [DATA_W-1:0] i_TableData,
   output logic              o_SCL,
   output logic              o_SDA_OE,
   input  logic              i_SDA,
   output logic              o_BUSY,
   output logic              o_DONE,
   output logic              o_ERROR,
   output logic [ADDR_W-1:0] o_FailIndex
);

   localparam int NB     = DATA_W / 8;
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BYTE_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
   localparam logic [ADDR_W-1:0] LAST_ENTRY  = ADDR_W'(NUM_ENTRIES - 1);
   localparam logic [BYTE_W-1:0] LAST_BYTE   = BYTE_W'(NB - 1);
   localparam logic [RTY_W-1:0]  RETRY_LIMIT = RTY_W'(MAX_RETRY);
   localparam logic [7:0]        ADDR_BYTE   = {DEV_ADDR, 1'b0};
   localparam logic [3:0]        ACK_BIT     = 4'd8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ADDR,
      S_DATA,
      S_STOP,
      S_GAP,
      S_ERROR
   } state_t;

   state_t              state;
   logic [DIV_W-1:0]    div_cnt;
   logic [1:0]          quarter;
   logic [3:0]          bit_cnt;     // 0..7 data bits, 8 = ACK bit
   logic [BYTE_W-1:0]   byte_cnt;
   logic [RTY_W-1:0]    retry_cnt;
   logic                nacked;      // current attempt saw a NACK
   logic [DATA_W-1:0]   word;
   logic [ADDR_W-1:0]   table_addr;
   logic [ADDR_W-1:0]   fail_index;
   logic                scl;
   logic                sda_oe;
   logic                busy;
   logic                done;
   logic                error;

   logic                tick;
   logic [DATA_W-1:0]   word_sh;
   logic [7:0]          tx_byte;
   logic                tx_bit;
   logic                scl_next;
   logic                oe_next;

   assign tick = (state != S_IDLE) && (div_cnt == DIV_LAST);

   // Bus levels for the current (state, quarter, bit). They are registered
   // below, so the pins follow the state by one clock; every quarter is
   // delayed equally, so SCL high/low times are exact.
   always_comb begin
      word_sh  = word << {byte_cnt, 3'b000};
      tx_byte  = (state == S_ADDR) ? ADDR_BYTE : word_sh[DATA_W-1 -: 8];
      tx_bit   = tx_byte[~bit_cnt[2:0]];
      scl_next = 1'b1;
      oe_next  = 1'b0;
      case (state)
         S_START: begin
            scl_next = (quarter != 2'd3);
            oe_next  = quarter[1];
         end
         S_ADDR, S_DATA: begin
            scl_next = (quarter == 2'd1) || (quarter == 2'd2);
            oe_next  = (bit_cnt == ACK_BIT) ? 1'b0 : ~tx_bit;
         end
         S_STOP: begin
            scl_next = (quarter != 2'd0);
            oe_next  = (quarter < 2'd2);
         end
         default: begin
            scl_next = 1'b1;
            oe_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (!i_NRESET) begin
         state      <= S_IDLE;
         div_cnt    <= '0;
         quarter    <= '0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         retry_cnt  <= '0;
         nacked     <= 1'b0;
         table_addr <= '0;
         fail_index <= '0;
         scl        <= 1'b1;
         sda_oe     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         scl    <= scl_next;
         sda_oe <= oe_next;

         if (state == S_IDLE || tick)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + 1'b1;

         case (state)
            S_IDLE: begin
               if (i_START) begin
                  done       <= 1'b0;
                  error      <= 1'b0;
                  busy       <= 1'b1;
                  table_addr <= '0;
                  retry_cnt  <= '0;
                  nacked     <= 1'b0;
                  quarter    <= '0;
                  state      <= S_START;
               end
            end

            S_START: begin
               if (tick) begin
                  quarter <= quarter + 1'b1;
                  // Address has been stable for two quarters by now, so a
                  // registered table ROM has had time to respond.
                  if (quarter == 2'd1)
                     word <= i_TableData;
                  if (quarter == 2'd3) begin
                     bit_cnt  <= '0;
                     byte_cnt <= '0;
                     state    <= S_ADDR;
                  end
               end
            end

            S_ADDR, S_DATA: begin
               if (tick) begin
                  quarter <= quarter + 1'b1;
                  if (quarter == 2'd1 && bit_cnt == ACK_BIT && i_SDA)
                     nacked <= 1'b1;
                  if (quarter == 2'd3) begin
                     if (bit_cnt != ACK_BIT) begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end else begin
                        bit_cnt <= '0;
                        // A NACK ends the entry after its ACK bit completes.
                        if (nacked) begin
                           state <= S_STOP;
                        end else if (state == S_ADDR) begin
                           byte_cnt <= '0;
                           state    <= S_DATA;
                        end else if (byte_cnt == LAST_BYTE) begin
                           state <= S_STOP;
                        end else begin
                           byte_cnt <= byte_cnt + 1'b1;
                        end
                     end
                  end
               end
            end

            S_STOP: begin
               if (tick) begin
                  quarter <= quarter + 1'b1;
                  if (quarter == 2'd3)
                     state <= S_GAP;
               end
            end

            S_GAP: begin
               if (tick) begin
                  quarter <= quarter + 1'b1;
                  if (quarter == 2'd3) begin
                     if (!nacked) begin
                        if (table_addr == LAST_ENTRY) begin
                           busy  <= 1'b0;
                           done  <= 1'b1;
                           state <= S_IDLE;
                        end else begin
                           table_addr <= table_addr + 1'b1;
                           retry_cnt  <= '0;
                           state      <= S_START;
                        end
                     end else if (retry_cnt < RETRY_LIMIT) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        nacked    <= 1'b0;
                        state     <= S_START;
                     end else begin
                        state <= S_ERROR;
                     end
                  end
               end
            end

            S_ERROR: begin
               error      <= 1'b1;
               done       <= 1'b1;
               busy       <= 1'b0;
               fail_index <= table_addr;
               state      <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign o_TableAddr = table_addr;
   assign o_FailIndex = fail_index;
   assign o_SCL       = scl;
   assign o_SDA_OE    = sda_oe;
   assign o_BUSY      = busy;
   assign o_DONE      = done;
   assign o_ERROR     = error;

endmodule

// File: tb/tb_i2c_codec_config_sequencer.sv
// Bench for i2c_codec_config_sequencer: directed sequences against a small
// I2C slave/bus decoder, plus three free-running instances at other clock
// dividers whose SCL/SDA timing is checked continuously.
module tb_i2c_codec_config_sequencer;

   localparam int CLK_DIV     = 4;
   localparam int NUM_ENTRIES = 2;
   localparam int ADDR_W      = 5;
   localparam int DATA_W      = 16;
   localparam int MAX_RETRY   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d want=%0d", tag, $signed(got), $signed(exp));
      end
   endtask

   // ---------------- main DUT ----------------
   logic              nreset = 1'b0;
   logic              start  = 1'b0;
   logic [ADDR_W-1:0] taddr;
   logic [DATA_W-1:0] tdata;
   logic              m_scl, m_oe, sda_line;
   logic              busy, done, err;
   logic [ADDR_W-1:0] fail;
   logic              pull = 1'b0;

   assign tdata    = (taddr == 0) ? 16'h1E00 : 16'h0C07;
   assign sda_line = ~(m_oe | pull);

   i2c_codec_config_sequencer #(
      .CLK_DIV(CLK_DIV), .DEV_ADDR(7'b0011010), .NUM_ENTRIES(NUM_ENTRIES),
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RETRY(MAX_RETRY)
   ) u_dut (
      .i_CLK(clk), .i_NRESET(nreset), .i_START(start),
      .o_TableAddr(taddr), .i_TableData(tdata),
      .o_SCL(m_scl), .o_SDA_OE(m_oe), .i_SDA(sda_line),
      .o_BUSY(busy), .o_DONE(done), .o_ERROR(err), .o_FailIndex(fail)
   );

   // Bus decoder + slave. Events: -1 START, -2 STOP, byte | 256 if NACKed.
   int         ev[$];
   logic       p_scl = 1'b1, p_sda = 1'b1;
   int         bitcnt = 0, bytei = 0;
   int         addr_nacked = 0, nack_addr_lim = 0;
   logic       nack_0c07 = 1'b0;
   logic [7:0] sh = 8'h00, b1 = 8'h00;

   always @(negedge clk) begin
      if (nreset) begin
         if (m_scl && p_scl && (sda_line != p_sda)) begin
            if (!sda_line) begin
               ev.push_back(-1);
               bitcnt = 0;
               bytei  = 0;
            end else begin
               ev.push_back(-2);
            end
         end else if (m_scl && !p_scl) begin
            if (bitcnt < 8) begin
               sh = {sh[6:0], sda_line};
               bitcnt++;
            end else begin
               ev.push_back(int'(sh) + (sda_line ? 256 : 0));
               if (bytei == 1) b1 = sh;
               bytei++;
               bitcnt = 0;
            end
         end else if (!m_scl && p_scl) begin
            if (bitcnt == 8) begin
               logic nk;
               nk = (bytei == 0 && addr_nacked < nack_addr_lim) ||
                    (nack_0c07 && bytei == 2 && b1 == 8'h0C);
               if (nk && bytei == 0) addr_nacked++;
               pull = !nk;
            end else begin
               pull = 1'b0;
            end
         end
      end
      p_scl = m_scl;
      p_sda = sda_line;
   end

   // ---------------- timing instances ----------------
   logic       g_nreset = 1'b0;
   logic       g_start  = 1'b0;
   logic [2:0] g_done, g_err, g_fail0;

   for (genvar g = 0; g < 3; g++) begin : g_div
      localparam int D = (g == 0) ? 2 : (g == 1) ? 5 : 125;
      logic              scl_g, oe_g, sda_g, busy_g, done_g, err_g;
      logic [ADDR_W-1:0] ta_g, fi_g;
      logic [DATA_W-1:0] td_g;

      // No slave on this bus: every ACK bit reads as NACK.
      assign sda_g = ~oe_g;
      assign td_g  = (ta_g == 0) ? 16'h1E00 : 16'h0C07;
      assign g_done[g]  = done_g;
      assign g_err[g]   = err_g;
      assign g_fail0[g] = (fi_g == 0);

      i2c_codec_config_sequencer #(
         .CLK_DIV(D), .DEV_ADDR(7'b0011010), .NUM_ENTRIES(2),
         .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RETRY(1)
      ) u_dut (
         .i_CLK(clk), .i_NRESET(g_nreset), .i_START(g_start),
         .o_TableAddr(ta_g), .i_TableData(td_g),
         .o_SCL(scl_g), .o_SDA_OE(oe_g), .i_SDA(sda_g),
         .o_BUSY(busy_g), .o_DONE(done_g), .o_ERROR(err_g), .o_FailIndex(fi_g)
      );

      int   hi_len = 0, n_chg = 0, since = 0;
      logic q_scl = 1'b1, q_sda = 1'b1;

      // Each SCL high period ends either as a clean data bit (2*D clocks, no
      // SDA change) or as a START whose SDA fall precedes the SCL fall by D.
      always @(negedge clk) begin
         if (g_nreset) begin
            if (scl_g && q_scl) begin
               hi_len++;
               if (sda_g != q_sda) begin
                  n_chg++;
                  since = 0;
               end else begin
                  since++;
               end
            end else if (scl_g) begin
               hi_len = 1;
               n_chg  = 0;
               since  = 0;
            end else if (q_scl) begin
               chk($sformatf("d%0d_scl_high", D),
                   (n_chg == 0) ? (hi_len == 2 * D) : (!q_sda && since == D - 1), 1);
            end
         end
         q_scl = scl_g;
         q_sda = sda_g;
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      g_nreset = 1'b1;
      @(negedge clk) g_start = 1'b1;
      @(negedge clk) g_start = 1'b0;
   end

   // ---------------- directed tests ----------------
   int exp_q[$];

   task automatic cmp_seq(input string tag, input int base);
      chk({tag, "_len"}, ev.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s_ev%0d", tag, i),
             (base + i < ev.size()) ? ev[base + i] : 999, exp_q[i]);
   endtask

   task automatic pulse_start;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output int c);
      int n = 0;
      while (!done && n < lim) begin
         @(negedge clk);
         n++;
      end
      c = cyc;
      chk("done_wait", done, 1);
   endtask

   int base, c0, c1, n0, n;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_scl", m_scl, 1);
      chk("rst_oe", m_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", taddr, 0);
      chk("rst_fail", fail, 0);
      nreset = 1'b1;
      repeat (2) @(negedge clk);

      // 1: all ACK, START re-pulsed while busy, latency 960 clocks
      base = ev.size();
      pulse_start();
      c0 = cyc;
      chk("t1_busy", busy, 1);
      repeat (200) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(3000, c1);
      chk("t1_latency", c1 - c0, 960);
      chk("t1_err", err, 0);
      chk("t1_busy_end", busy, 0);
      exp_q = '{-1, 'h34, 'h1E, 'h00, -2, -1, 'h34, 'h0C, 'h07, -2};
      cmp_seq("t1", base);

      // 2: one NACK on entry 0 address; restart clears DONE
      nack_addr_lim = 1;
      base = ev.size();
      pulse_start();
      chk("t2_done_clr", done, 0);
      chk("t2_busy", busy, 1);
      wait_done(5000, c1);
      chk("t2_err", err, 0);
      exp_q = '{-1, 'h134, -2, -1, 'h34, 'h1E, 'h00, -2, -1, 'h34, 'h0C, 'h07, -2};
      cmp_seq("t2", base);

      // 3: permanent NACK on second data byte of entry 1
      nack_0c07 = 1'b1;
      base = ev.size();
      pulse_start();
      wait_done(10000, c1);
      chk("t3_err", err, 1);
      chk("t3_fail", fail, 1);
      chk("t3_busy", busy, 0);
      exp_q = '{-1, 'h34, 'h1E, 'h00, -2,
                -1, 'h34, 'h0C, 'h107, -2,
                -1, 'h34, 'h0C, 'h107, -2,
                -1, 'h34, 'h0C, 'h107, -2};
      cmp_seq("t3", base);
      n0 = ev.size();
      repeat (400) @(negedge clk);
      chk("t3_quiet", ev.size(), n0);
      chk("t3_scl", m_scl, 1);
      chk("t3_oe", m_oe, 0);

      // 4: one-cycle reset inside a data byte, then full replay
      nack_0c07 = 1'b0;
      base = ev.size();
      pulse_start();
      n = 0;
      while (ev.size() < base + 2 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("t4_addr_seen", ev.size() >= base + 2, 1);
      repeat (30) @(negedge clk);
      chk("t4_busy_pre", busy, 1);
      nreset = 1'b0;
      @(negedge clk) nreset = 1'b1;
      chk("t4_scl", m_scl, 1);
      chk("t4_oe", m_oe, 0);
      chk("t4_busy", busy, 0);
      chk("t4_done", done, 0);
      chk("t4_err", err, 0);
      chk("t4_addr", taddr, 0);
      chk("t4_fail", fail, 0);
      repeat (20) @(negedge clk);
      chk("t4_idle", busy, 0);
      base = ev.size();
      pulse_start();
      wait_done(3000, c1);
      chk("t4_err_end", err, 0);
      exp_q = '{-1, 'h34, 'h1E, 'h00, -2, -1, 'h34, 'h0C, 'h07, -2};
      cmp_seq("t4", base);

      // timing instances: NACK everywhere, MAX_RETRY=1 -> error on entry 0
      n = 0;
      while (g_done != 3'b111 && n < 30000) begin
         @(negedge clk);
         n++;
      end
      chk("g_done", g_done, 3'b111);
      chk("g_err", g_err, 3'b111);
      chk("g_fail0", g_fail0, 3'b111);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
